// File: rtl/apb_master.sv
// APB requester: one SETUP/ACCESS transfer per command, response on a
// valid/ready port, with a wait-state timeout against stuck completers.
module apb_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic              i_clk_apb,
    input  logic              i_rst_apb,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic              i_cmd_rd0_wr1,
    input  logic [DATA_W-1:0] i_cmd_wr_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rd_data,
    output logic              o_rsp_err,
    output logic              o_timeout,
    output logic              o_psel,
    output logic              o_penable,
    output logic [ADDR_W-1:0] o_paddr,
    output logic              o_pwrite,
    output logic [DATA_W-1:0] o_pwdata,
    input  logic              i_pready,
    input  logic [DATA_W-1:0] i_prdata,
    input  logic              i_pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam bit              LP_TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_psel, w_psel_nxt;
    logic                r_penable, w_penable_nxt;
    logic [ADDR_W-1:0]   r_paddr, w_paddr_nxt;
    logic                r_pwrite, w_pwrite_nxt;
    logic [DATA_W-1:0]   r_pwdata, w_pwdata_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_rd_data, w_rsp_rd_data_nxt;
    logic                r_rsp_err, w_rsp_err_nxt;
    logic                r_timeout, w_timeout_nxt;
    logic                w_cmd_hs;
    logic                w_rsp_hs;

    assign o_cmd_ready = (r_state == S_IDLE) && !i_rst_apb;
    assign w_cmd_hs    = i_cmd_valid && o_cmd_ready;
    assign w_rsp_hs    = r_rsp_valid && i_rsp_ready;

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_psel_nxt        = r_psel;
        w_penable_nxt     = r_penable;
        w_paddr_nxt       = r_paddr;
        w_pwrite_nxt      = r_pwrite;
        w_pwdata_nxt      = r_pwdata;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rd_data_nxt = r_rsp_rd_data;
        w_rsp_err_nxt     = r_rsp_err;
        w_timeout_nxt     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_cmd_hs) begin
                    w_paddr_nxt   = i_cmd_addr;
                    w_pwrite_nxt  = i_cmd_rd0_wr1;
                    w_pwdata_nxt  = i_cmd_rd0_wr1 ? i_cmd_wr_data : '0;
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b0;
                    w_state_nxt   = S_SETUP;
                end
            end
            S_SETUP: begin
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
                w_state_nxt   = S_ACCESS;
            end
            S_ACCESS: begin
                // A ready completer beats a timeout firing on the same edge
                if (i_pready) begin
                    w_rsp_rd_data_nxt = r_pwrite ? '0 : i_prdata;
                    w_rsp_err_nxt     = i_pslverr;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = S_RESP;
                end else if (LP_TO_EN && (r_cnt == LP_TO_LAST)) begin
                    w_rsp_rd_data_nxt = '0;
                    w_rsp_err_nxt     = 1'b1;
                    w_timeout_nxt     = 1'b1;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RESP: begin
                if (w_rsp_hs) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_apb) begin
        if (i_rst_apb) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rd_data <= '0;
            r_rsp_err     <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_psel        <= w_psel_nxt;
            r_penable     <= w_penable_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwrite      <= w_pwrite_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rd_data <= w_rsp_rd_data_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    assign o_psel        = r_psel;
    assign o_penable     = r_penable;
    assign o_paddr       = r_paddr;
    assign o_pwrite      = r_pwrite;
    assign o_pwdata      = r_pwdata;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rd_data = r_rsp_rd_data;
    assign o_rsp_err     = r_rsp_err;
    assign o_timeout     = r_timeout;

endmodule
